sel_mux_pipe: RTL and testbench
===============================

Name: sel_mux_pipe

Overview:
Parametrised, pipelined N-input line-select multiplexer for the L2 cache datapath. It replaces the fixed 16-input combinational mux on the way/line read path.
- Accepts a flattened bus of NUM_IN candidate words plus a select. The select is either a binary index or a one-hot hit vector.
- Registers the chosen word behind a valid/ready handshake with a 2-entry skid buffer, so the cache can stall without dropping a read.

Parameters:
WIDTH, 256, bits per candidate word (cache line).
NUM_IN, 16, number of candidate inputs; must be ≥2.
SEL_W, $clog2(NUM_IN), binary select width; localparam, derived, not overridable.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  synchronous active-low reset.
in_valid  input  1  input beat present.
in_ready  output  1  block can accept a beat this cycle.
in_data  input  NUM_IN*WIDTH  candidates; word k at bits [k*WIDTH +: WIDTH].
in_mode  input  1  0 = binary select via in_sel; 1 = one-hot select via in_hit.
in_sel  input  SEL_W  binary index.
in_hit  input  NUM_IN  hit vector (one-hot expected).
out_valid  output  1  output beat present.
out_ready  input  1  consumer accepts beat.
out_data  output  WIDTH  selected word.
out_idx  output  SEL_W  index actually selected.
out_miss  output  1  beat came from one-hot mode with in_hit == 0.
sel_err  output  1  only when SEL_ONEHOT_CHECK_EN is defined; see Optional Feature.

Behaviour:
- Reset (rst_n low at a clk edge):
  - out_valid=0, out_data=0, out_idx=0, out_miss=0, sel_err=0, in_ready=1.
  - Both skid entries are invalidated.
  - Reset overrides any same-cycle handshake; a beat in flight mid-operation is discarded.
- Transfer rules:
  - Input transfer on in_valid & in_ready.
  - Output transfer on out_valid & out_ready.
  - out_data, out_idx and out_miss hold stable while out_valid & !out_ready.
- Select resolution (combinational, applied at input transfer):
  - Binary mode: idx = in_sel. If in_sel ≥ NUM_IN (NUM_IN not a power of 2), data = 0 and idx = in_sel.
  - One-hot mode: idx = lowest set bit of in_hit. If in_hit == 0: data = 0, idx = 0, miss = 1.
- Storage: 2-entry FIFO (main + skid). State EMPTY/ONE/TWO, held as a count 0..2.
  - EMPTY: in xfer → ONE.
  - ONE: in xfer & !out xfer → TWO; out xfer & !in xfer → EMPTY; both or neither → ONE.
  - TWO: out xfer → ONE. No input accepted.
- in_ready = (count != 2). It is registered, a pure function of state, and does not depend on out_ready combinationally.
- Latency: a beat accepted at edge n appears on out_valid after edge n, i.e. 1 cycle. Throughput is 1 beat/cycle while out_ready stays high.
- Ordering is strict FIFO; the output always presents the oldest entry.
- Simultaneous in and out transfer in ONE: the new beat replaces the presented beat on the next cycle, with no bubble.

Optional Feature:
Macro SEL_ONEHOT_CHECK_EN.
- Defined:
  - sel_err is a registered output, reset 0, travelling with each beat.
  - It is 1 for a beat accepted in one-hot mode whose in_hit has more than one bit set.
  - Selection remains lowest-set-bit.
  - Simulation-only $error on such accept.
- Undefined: sel_err tied 0. No popcount logic and no assertion.

Test Plan:
1. Reset then binary: rst_n=0 for 2 cycles with in_valid=1 → out_valid=0, in_ready=1. Release, in_sel=5, word k = k*0x11 → next cycle out_data=0x55, out_idx=5, out_miss=0.
2. One-hot stream: in_mode=1, in_hit=16'h0100, out_ready=1, 8 back-to-back beats → out_idx=8 on every cycle, 1-cycle latency, no bubbles.
3. Backpressure: out_ready=0, send 3 beats with sel=1,2,3 → in_ready drops after 2 accepts, beat 3 held off. Raise out_ready → outputs 1,2,3 in order, none lost.
4. Miss / out of range: in_mode=1, in_hit=0 → out_data=0, out_idx=0, out_miss=1. NUM_IN=12, binary in_sel=13 → out_data=0, out_idx=13.
5. Multi-hit with SEL_ONEHOT_CHECK_EN: in_hit=16'h0090 → out_idx=4, sel_err=1. Same stimulus without the macro → sel_err=0.
6. Mid-operation reset: FIFO in TWO state, pulse rst_n=0 for one cycle → out_valid=0 and in_ready=1 next cycle, no stale beat emitted afterwards.

Source files
------------

// File: rtl/sel_mux_pipe.sv
// Pipelined N-input line-select mux with a 2-entry skid FIFO on the output.
// Optional one-hot multi-hit flag: define SEL_ONEHOT_CHECK_EN.
module sel_mux_pipe #(
    parameter  int WIDTH  = 256,
    parameter  int NUM_IN = 16,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic                    in_mode,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic [NUM_IN-1:0]       in_hit,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_idx,
    output logic                    out_miss,
    output logic                    sel_err
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SEL_W-1:0] idx;
        logic             miss;
`ifdef SEL_ONEHOT_CHECK_EN
        logic             err;
`endif
    } entry_t;

    entry_t     res;
    entry_t     head_q, head_d;
    entry_t     tail_q, tail_d;
    logic [1:0] count_q, count_d;
    logic       in_ready_q, in_ready_d;
    logic       push, pop;

    always_comb begin
        res = '0;
        if (!in_mode) begin
            res.idx = in_sel;
            // out-of-range index matches no candidate and leaves data at zero
            for (int k = 0; k < NUM_IN; k++) begin
                if (in_sel == SEL_W'(k)) begin
                    res.data = in_data[k*WIDTH +: WIDTH];
                end
            end
        end else if (in_hit == '0) begin
            res.miss = 1'b1;
        end else begin
            // descending scan so the lowest set bit wins
            for (int k = NUM_IN - 1; k >= 0; k--) begin
                if (in_hit[k]) begin
                    res.idx  = SEL_W'(k);
                    res.data = in_data[k*WIDTH +: WIDTH];
                end
            end
        end
`ifdef SEL_ONEHOT_CHECK_EN
        res.err = in_mode & (|(in_hit & (in_hit - NUM_IN'(1))));
`endif
    end

    assign push = in_valid & in_ready_q;
    assign pop  = (count_q != 2'd0) & out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q    <= 2'd0;
            head_q     <= '0;
            tail_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            in_ready_q <= in_ready_d;
        end
    end

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        unique case (count_q)
            2'd0: begin
                if (push) begin
                    head_d  = res;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_d = res;
                end else if (push) begin
                    tail_d  = res;
                    count_d = 2'd2;
                end else if (pop) begin
                    count_d = 2'd0;
                end
            end
            2'd2: begin
                if (pop) begin
                    head_d  = tail_q;
                    count_d = 2'd1;
                end
            end
            default: count_d = 2'd0;
        endcase
        in_ready_d = (count_d != 2'd2);
    end

    always_comb begin
        in_ready  = in_ready_q;
        out_valid = (count_q != 2'd0);
        out_data  = head_q.data;
        out_idx   = head_q.idx;
        out_miss  = head_q.miss;
`ifdef SEL_ONEHOT_CHECK_EN
        sel_err   = head_q.err;
`else
        sel_err   = 1'b0;
`endif
    end

`ifdef SEL_ONEHOT_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            assert (!res.err)
            else $error("sel_mux_pipe: multi-hit select %0h", in_hit);
        end
    end
`endif

endmodule

// File: tb/tb_sel_mux_pipe.sv
// Directed bench for sel_mux_pipe with a queue scoreboard on the output.
module tb_sel_mux_pipe;

    localparam int W = 256;
`ifdef SEL_ONEHOT_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] d;
        logic [3:0]   i;
        logic         m;
        logic         e;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic           in_valid, in_ready, in_mode;
    logic [16*W-1:0] in_data;
    logic [3:0]     in_sel;
    logic [15:0]    in_hit;
    logic           out_valid, out_ready;
    logic [W-1:0]   out_data;
    logic [3:0]     out_idx;
    logic           out_miss, sel_err;

    logic           v12, r12, ov12, miss12, err12;
    logic [12*W-1:0] data12;
    logic [3:0]     sel12, idx12;
    logic [W-1:0]   od12;

    int total = 0;
    int bad   = 0;
    exp_t q[$];

    sel_mux_pipe #(.WIDTH(W), .NUM_IN(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mode(in_mode),
        .in_sel(in_sel), .in_hit(in_hit),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx),
        .out_miss(out_miss), .sel_err(sel_err)
    );

    sel_mux_pipe #(.WIDTH(W), .NUM_IN(12)) dut12 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v12), .in_ready(r12),
        .in_data(data12), .in_mode(1'b0),
        .in_sel(sel12), .in_hit(12'h000),
        .out_valid(ov12), .out_ready(1'b1),
        .out_data(od12), .out_idx(idx12),
        .out_miss(miss12), .sel_err(err12)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic mode, input logic [3:0] sel,
                                   input logic [15:0] hit,
                                   input logic [16*W-1:0] data);
        exp_t r;
        r = '0;
        if (!mode) begin
            r.i = sel;
            r.d = data[sel*W +: W];
        end else if (hit == 16'h0) begin
            r.m = 1'b1;
        end else begin
            for (int k = 15; k >= 0; k--) if (hit[k]) r.i = k[3:0];
            r.d = data[r.i*W +: W];
            r.e = ERR_EN && ($countones(hit) > 1);
        end
        return r;
    endfunction

    task automatic pattern_data();
        for (int k = 0; k < 16; k++) in_data[k*W +: W] = W'(k * 'h11);
        for (int k = 0; k < 12; k++) data12[k*W +: W] = W'(k * 'h11);
    endtask

    task automatic rand_data();
        for (int k = 0; k < 16; k++)
            in_data[k*W +: W] = {8{$urandom}};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("sb_stale_beat", W'(1), W'(0));
                end else begin
                    e = q.pop_front();
                    chk("sb_data", out_data, e.d);
                    chk("sb_idx", W'(out_idx), W'(e.i));
                    chk("sb_miss", W'(out_miss), W'(e.m));
                    chk("sb_err", W'(sel_err), W'(e.e));
                end
            end
            if (in_valid && in_ready)
                q.push_back(model(in_mode, in_sel, in_hit, in_data));
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; in_mode = 1'b0;
        in_sel = 4'd5; in_hit = 16'h0; out_ready = 1'b1;
        v12 = 1'b0; sel12 = 4'd0;
        pattern_data();

        // 1: reset with in_valid high, then a binary select
        repeat (2) step();
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_in_ready", W'(in_ready), W'(1));
        chk("rst_out_data", out_data, W'(0));
        chk("rst_out_idx", W'(out_idx), W'(0));
        chk("rst_sel_err", W'(sel_err), W'(0));
        rst_n = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t1_valid", W'(out_valid), W'(1));
        chk("t1_data", out_data, W'('h55));
        chk("t1_idx", W'(out_idx), W'(5));
        chk("t1_miss", W'(out_miss), W'(0));
        step();

        // 2: one-hot stream, no bubbles
        in_valid = 1'b1; in_mode = 1'b1; in_hit = 16'h0100;
        for (int i = 0; i < 8; i++) begin
            rand_data();
            step();
            chk("t2_valid", W'(out_valid), W'(1));
            chk("t2_idx", W'(out_idx), W'(8));
            chk("t2_in_ready", W'(in_ready), W'(1));
        end
        in_valid = 1'b0;
        step();
        chk("t2_drain", W'(out_valid), W'(0));

        // 3: backpressure fills both entries
        pattern_data();
        out_ready = 1'b0; in_mode = 1'b0; in_valid = 1'b1; in_sel = 4'd1;
        step();
        chk("t3_rdy_one", W'(in_ready), W'(1));
        in_sel = 4'd2;
        step();
        chk("t3_rdy_two", W'(in_ready), W'(0));
        in_sel = 4'd3;
        step();
        chk("t3_rdy_held", W'(in_ready), W'(0));
        chk("t3_hold_data", out_data, W'('h11));
        out_ready = 1'b1;
        step();
        chk("t3_second", out_data, W'('h22));
        step();
        chk("t3_third", out_data, W'('h33));
        in_valid = 1'b0;
        step();
        chk("t3_empty", W'(out_valid), W'(0));

        // 4: one-hot miss, and out-of-range on the 12-input instance
        in_valid = 1'b1; in_mode = 1'b1; in_hit = 16'h0;
        step();
        in_valid = 1'b0;
        chk("t4_miss_data", out_data, W'(0));
        chk("t4_miss_idx", W'(out_idx), W'(0));
        chk("t4_miss_flag", W'(out_miss), W'(1));
        v12 = 1'b1; sel12 = 4'd13;
        step();
        chk("t4_oor_valid", W'(ov12), W'(1));
        chk("t4_oor_data", od12, W'(0));
        chk("t4_oor_idx", W'(idx12), W'(13));
        sel12 = 4'd11;
        step();
        v12 = 1'b0;
        chk("t4_inr_data", od12, W'('hBB));
        chk("t4_inr_idx", W'(idx12), W'(11));

        // 5: multi-hit picks lowest bit
        in_valid = 1'b1; in_mode = 1'b1; in_hit = 16'h0090;
        step();
        in_valid = 1'b0;
        chk("t5_idx", W'(out_idx), W'(4));
        chk("t5_data", out_data, W'('h44));
        chk("t5_sel_err", W'(sel_err), W'(ERR_EN));
        step();

        // 6: reset while holding two beats
        out_ready = 1'b0; in_mode = 1'b0; in_valid = 1'b1; in_sel = 4'd6;
        step();
        in_sel = 4'd7;
        step();
        chk("t6_full", W'(in_ready), W'(0));
        rst_n = 1'b0;
        step();
        chk("t6_rst_valid", W'(out_valid), W'(0));
        chk("t6_rst_ready", W'(in_ready), W'(1));
        chk("t6_rst_data", out_data, W'(0));
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t6_no_stale", W'(out_valid), W'(0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
